orb_frame_packer: RTL and testbench
===================================

# orb_frame_packer

Parametrised successor of the two-channel fast/slow packer: on each frame-slot request it drains a fixed word count from each of CH telemetry FIFOs and writes the words into whichever half of the ping-pong orbital RAM is not being read out. Each channel lands at its own base address, and short FIFOs are padded with a fill word. The block generates the per-bank write enables directly, so the top level no longer has to mux them. It sits between the per-UART writer FIFOs and the two M16 frame RAMs, all in the clk80MHz domain.

## Interface
Parameters:
- CH, 4, number of source FIFOs (1..8)
- WORD_W, 12, orbital word width
- ADDR_W, 11, RAM address width
- USEDW_W, 5, FIFO fill-count width
- WORDS, 16, words taken per channel per request (1..2^USEDW_W-1)
- FILL, all ones, pad word written when a FIFO runs short

Ports:
- clk  in  1  packer clock (clk80MHz domain)
- rst  in  1  asynchronous active-low reset
- rq  in  1  frame-slot request, already synchronous to clk; rising edge starts a burst
- sw  in  1  RAM bank currently read by the frame generator
- base_addr  in  CH*ADDR_W  per-channel start address; channel i occupies slice i
- usedw  in  CH*USEDW_W  per-channel FIFO fill count
- fifo_q  in  CH*WORD_W  per-channel FIFO data (normal mode, 1-cycle read latency)
- rdreq  out  CH  per-channel FIFO pop
- waddr  out  ADDR_W  RAM write address
- wdata  out  WORD_W  RAM write data
- wren0  out  1  bank-0 write strobe
- wren1  out  1  bank-1 write strobe
- busy  out  1  high from the burst start cycle through the last write
- underrun  out  CH  per-channel pad flags of the last completed burst
- overrun  out  1  sticky; set when a rising edge of rq arrives while busy

## Operation
- States: IDLE, START, READ, FLUSH, STAT (macro only).
- IDLE: on a rising edge of rq, go to START.
- START:
  - latch bank = ~sw; the bank is held for the whole burst, and sw changes mid-burst are ignored
  - set ch = 0, k = 0
  - latch avail = min(usedw[ch], WORDS)
- READ:
  - one output word per cycle for k = 0..WORDS-1
  - if k < avail, pulse rdreq[ch]; otherwise schedule FILL
  - after k = WORDS-1: if ch < CH-1, advance ch, reset k, latch the new avail, and stay in READ with no gap cycle; otherwise go to FLUSH
- Write pipeline, one stage:
  - the word chosen at cycle t is written at t+1
  - wdata = fifo_q[ch] for a popped word, FILL for a pad
  - waddr = base_addr[ch] + k, truncated to ADDR_W bits (wraps at 2^ADDR_W)
  - exactly one of wren0/wren1 is high, according to the latched bank
- FLUSH:
  - the last write completes
  - underrun[i] is updated to (avail_i < WORDS) for every channel
  - go to IDLE (or STAT)
- rdreq is only asserted for words covered by the latched avail, so an empty FIFO is never popped.
- Overlapping address ranges are not checked; later channels overwrite earlier ones.

## Timing
- Reset values: all outputs 0, state IDLE, internal bank 0, rq edge register 0.
- rq edge seen at cycle 0:
  - START at cycle 1
  - first rdreq at cycle 2
  - first write at cycle 3
  - last write at cycle 2+CH*WORDS
  - busy deasserts at cycle 3+CH*WORDS (+1 with STAT)
- Throughput is one word per clock; there are no bubbles between channels.
- A rising edge of rq while busy is dropped and sets overrun. overrun clears only on reset.
- Reset mid-burst: all outputs drop to 0 immediately. No partial-write cleanup is done; the next burst overwrites the bank.
- usedw is sampled only once per channel, at that channel's start cycle.

## Configuration
- ORB_PACKER_STATUS_EN defined:
  - after FLUSH, one extra write in state STAT
  - address base_addr[0] + CH*WORDS (wrapped), same bank
  - data = {8-bit burst counter, underrun flags}, zero-extended or truncated to WORD_W
  - the burst counter increments per burst and wraps at 255
- Undefined: no STAT state and no counter; FLUSH returns straight to IDLE.

## Structure
- Package orb_pkg holds:
  - state enum
  - default parameter constants (ORB_WORD_W=12, ORB_ADDR_W=11)
  - FILL default
- One natural sub-module, orb_rq_edge: rising-edge detector plus the busy/overrun logic.

## Test plan
- CH=4, WORDS=16, all usedw=20, sw=0 → 64 writes on wren1 only; channel i at base_i..base_i+15 with its FIFO order preserved; underrun=0; busy low at cycle 67.
- Channel 2 usedw=5 → exactly 5 rdreq[2]; 11 FILL words at base_2+5..+15; underrun=4'b0100.
- base_addr[3]=2040, WORDS=16 → addresses 2040..2047 then 0..7.
- Second rq edge at cycle 10 of a burst → ignored; overrun=1; the burst completes unchanged.
- sw toggles mid-burst → all writes stay on the bank latched at START.
- rst low at cycle 20 → rdreq/wren0/wren1/busy all 0 the same cycle; the next rq edge runs a full burst. With ORB_PACKER_STATUS_EN, the status word holds counter=1 and the underrun bits.

Source files
------------

// File: rtl/orb_pkg.sv
// rtl/orb_pkg.sv - shared state type and default constants for the orbital frame packer
package orb_pkg;
  localparam int          ORB_WORD_W = 12;
  localparam int          ORB_ADDR_W = 11;
  localparam logic [31:0] ORB_FILL   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    FLUSH,
    STAT
  } orb_state_t;
endpackage

// File: rtl/orb_rq_edge.sv
// rtl/orb_rq_edge.sv - frame-slot request edge detector with busy and sticky overrun tracking
module orb_rq_edge (
  input  logic clk,
  input  logic rst,
  input  logic rq,
  input  logic done,
  output logic start,
  output logic busy,
  output logic overrun
);
  logic rq_d;
  logic rq_rise;

  assign rq_rise = rq & ~rq_d;
  assign start   = rq_rise & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_d    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rq_d <= rq;
      if (start) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      // a request landing on a running burst is dropped, only remembered here
      if (rq_rise && busy) begin
        overrun <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/orb_frame_packer.sv
// rtl/orb_frame_packer.sv - drains CH telemetry FIFOs into the idle half of the ping-pong orbital RAM
// Optional trailing status word per burst: ORB_PACKER_STATUS_EN.
module orb_frame_packer
  import orb_pkg::*;
#(
  parameter int                CH      = 4,
  parameter int                WORD_W  = ORB_WORD_W,
  parameter int                ADDR_W  = ORB_ADDR_W,
  parameter int                USEDW_W = 5,
  parameter int                WORDS   = 16,
  parameter logic [WORD_W-1:0] FILL    = WORD_W'(ORB_FILL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rq,
  input  logic                  sw,
  input  logic [CH*ADDR_W-1:0]  base_addr,
  input  logic [CH*USEDW_W-1:0] usedw,
  input  logic [CH*WORD_W-1:0]  fifo_q,
  output logic [CH-1:0]         rdreq,
  output logic [ADDR_W-1:0]     waddr,
  output logic [WORD_W-1:0]     wdata,
  output logic                  wren0,
  output logic                  wren1,
  output logic                  busy,
  output logic [CH-1:0]         underrun,
  output logic                  overrun
);
  localparam int                 CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CH_W-1:0]    LAST_CH = CH_W'(CH - 1);
  localparam logic [USEDW_W-1:0] WORDS_C = USEDW_W'(WORDS);
  localparam logic [USEDW_W-1:0] LAST_K  = USEDW_W'(WORDS - 1);

  logic [ADDR_W-1:0]  base_a  [CH];
  logic [USEDW_W-1:0] usedw_a [CH];
  logic [WORD_W-1:0]  q_a     [CH];

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      base_a[i]  = base_addr[i*ADDR_W +: ADDR_W];
      usedw_a[i] = usedw[i*USEDW_W +: USEDW_W];
      q_a[i]     = fifo_q[i*WORD_W +: WORD_W];
    end
  end

  orb_state_t         state;
  logic               bank;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    ch_w;
  logic [USEDW_W-1:0] k;
  logic [USEDW_W-1:0] avail;
  logic [CH-1:0]      short_acc;
  logic               pop_w;
  logic               start;
  logic               done;

  orb_rq_edge u_rq_edge (
    .clk     (clk),
    .rst     (rst),
    .rq      (rq),
    .done    (done),
    .start   (start),
    .busy    (busy),
    .overrun (overrun)
  );

  // Lookahead to the channel about to start, so its pop is registered with no gap cycle
  logic [CH_W-1:0]    ch_nx;
  logic [USEDW_W-1:0] used_nx;
  logic [USEDW_W-1:0] avail_nx;

  always_comb begin
    ch_nx    = (state == START) ? '0 : ch + 1'b1;
    used_nx  = usedw_a[ch_nx];
    avail_nx = (used_nx < WORDS_C) ? used_nx : WORDS_C;
  end

`ifdef ORB_PACKER_STATUS_EN
  logic [7:0]        burst_cnt;
  logic              stat_w;
  logic [WORD_W-1:0] stat_word;

  assign done = (state == STAT);
`else
  assign done = (state == FLUSH);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bank      <= 1'b0;
      ch        <= '0;
      ch_w      <= '0;
      k         <= '0;
      avail     <= '0;
      short_acc <= '0;
      pop_w     <= 1'b0;
      rdreq     <= '0;
      waddr     <= '0;
      wren0     <= 1'b0;
      wren1     <= 1'b0;
      underrun  <= '0;
`ifdef ORB_PACKER_STATUS_EN
      burst_cnt <= '0;
      stat_w    <= 1'b0;
      stat_word <= '0;
`endif
    end else begin
      rdreq <= '0;
      wren0 <= 1'b0;
      wren1 <= 1'b0;
      pop_w <= 1'b0;
`ifdef ORB_PACKER_STATUS_EN
      stat_w <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= START;
          end
        end
        START: begin
          bank      <= ~sw;
          ch        <= ch_nx;
          k         <= '0;
          avail     <= avail_nx;
          short_acc <= '0;
          short_acc[ch_nx] <= (avail_nx < WORDS_C);
          if (avail_nx != '0) begin
            rdreq <= CH'(1) << ch_nx;
          end
          state <= READ;
        end
        READ: begin
          // word chosen now is written next cycle, when a popped FIFO word is on fifo_q
          waddr <= base_a[ch] + ADDR_W'(k);
          wren0 <= ~bank;
          wren1 <= bank;
          pop_w <= (k < avail);
          ch_w  <= ch;
          if (k != LAST_K) begin
            k <= k + 1'b1;
            if ((k + 1'b1) < avail) begin
              rdreq <= CH'(1) << ch;
            end
          end else if (ch != LAST_CH) begin
            ch    <= ch_nx;
            k     <= '0;
            avail <= avail_nx;
            short_acc[ch_nx] <= (avail_nx < WORDS_C);
            if (avail_nx != '0) begin
              rdreq <= CH'(1) << ch_nx;
            end
          end else begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          underrun <= short_acc;
`ifdef ORB_PACKER_STATUS_EN
          burst_cnt <= burst_cnt + 8'd1;
          waddr     <= base_a[0] + ADDR_W'(CH * WORDS);
          wren0     <= ~bank;
          wren1     <= bank;
          stat_w    <= 1'b1;
          stat_word <= WORD_W'({burst_cnt + 8'd1, short_acc});
          state     <= STAT;
`else
          state <= IDLE;
`endif
        end
`ifdef ORB_PACKER_STATUS_EN
        STAT: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wdata = '0;
    if (wren0 || wren1) begin
      wdata = pop_w ? q_a[ch_w] : FILL;
    end
`ifdef ORB_PACKER_STATUS_EN
    if (stat_w) begin
      wdata = stat_word;
    end
`endif
  end
endmodule

// File: tb/tb_orb_frame_packer.sv
// tb/tb_orb_frame_packer.sv - directed self-checking bench for orb_frame_packer
`timescale 1ns/1ps
module tb_orb_frame_packer;
  localparam int CH      = 4;
  localparam int WORD_W  = 12;
  localparam int ADDR_W  = 11;
  localparam int USEDW_W = 5;
  localparam int WORDS   = 16;
  localparam int NW      = CH * WORDS;
`ifdef ORB_PACKER_STATUS_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif
  localparam logic [WORD_W-1:0] FILLW = 12'hFFF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  rq  = 1'b0;
  logic                  sw  = 1'b0;
  logic [CH*ADDR_W-1:0]  base_addr;
  logic [CH*USEDW_W-1:0] usedw;
  logic [CH*WORD_W-1:0]  fifo_q;
  logic [CH-1:0]         rdreq;
  logic [ADDR_W-1:0]     waddr;
  logic [WORD_W-1:0]     wdata;
  logic                  wren0;
  logic                  wren1;
  logic                  busy;
  logic [CH-1:0]         underrun;
  logic                  overrun;

  logic [ADDR_W-1:0]  base [CH];
  logic [USEDW_W-1:0] used [CH];
  int                 pops [CH] = '{default: 0};

  int errors = 0;
  int checks = 0;

  int                w_addr [$];
  logic [WORD_W-1:0] w_data [$];
  logic              w_b1   [$];
  int                w_cyc  [$];
  int                rd_cnt [CH];
  int                p0     [CH];
  int                busy_fall;
  int                first_rd;
  logic              both;
  logic              b_sw;

  orb_frame_packer dut (
    .clk       (clk),
    .rst       (rst),
    .rq        (rq),
    .sw        (sw),
    .base_addr (base_addr),
    .usedw     (usedw),
    .fifo_q    (fifo_q),
    .rdreq     (rdreq),
    .waddr     (waddr),
    .wdata     (wdata),
    .wren0     (wren0),
    .wren1     (wren1),
    .busy      (busy),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] word(input int c, input int n);
    return WORD_W'(((c + 1) << 8) | (n & 255));
  endfunction

  // FIFO model: normal mode, popped word appears the cycle after rdreq
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (rdreq[i] === 1'b1) pops[i] <= pops[i] + 1;
    end
  end

  always_comb begin
    base_addr = '0;
    usedw     = '0;
    fifo_q    = '0;
    for (int i = 0; i < CH; i++) begin
      base_addr[i*ADDR_W +: ADDR_W]   = base[i];
      usedw[i*USEDW_W +: USEDW_W]     = used[i];
      fifo_q[i*WORD_W +: WORD_W]      = word(i, pops[i] - 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic do_burst(input int ovr_cyc, input int sw_cyc);
    w_addr.delete();
    w_data.delete();
    w_b1.delete();
    w_cyc.delete();
    busy_fall = -1;
    first_rd  = -1;
    both      = 1'b0;
    for (int i = 0; i < CH; i++) begin
      rd_cnt[i] = 0;
      p0[i]     = pops[i];
    end
    rq = 1'b0;
    @(posedge clk);
    #1;
    rq   = 1'b1;
    b_sw = sw;
    for (int c = 0; c < 300 && busy_fall < 0; c++) begin
      @(negedge clk);
      if (rdreq !== '0 && first_rd < 0) first_rd = c;
      for (int i = 0; i < CH; i++) begin
        if (rdreq[i] === 1'b1) rd_cnt[i]++;
      end
      if (wren0 === 1'b1 && wren1 === 1'b1) both = 1'b1;
      if (wren0 === 1'b1 || wren1 === 1'b1) begin
        w_addr.push_back(int'(waddr));
        w_data.push_back(wdata);
        w_b1.push_back(wren1);
        w_cyc.push_back(c);
      end
      if (c > 0 && busy === 1'b0) busy_fall = c;
      @(posedge clk);
      #1;
      if (c + 1 == 2) rq = 1'b0;
      if (c + 1 == ovr_cyc) rq = 1'b1;
      if (c + 1 == sw_cyc) sw = ~sw;
    end
  endtask

  task automatic check_burst(input string tag, input logic [CH-1:0] exp_under, input int exp_cnt);
    int bad;
    int av;
    int ch;
    int kk;
    int ea;
    logic [WORD_W-1:0] ed;
    bad = 0;
    for (int j = 0; j < NW; j++) begin
      ch = j / WORDS;
      kk = j % WORDS;
      av = (used[ch] < WORDS) ? int'(used[ch]) : WORDS;
      ea = (int'(base[ch]) + kk) % 2048;
      ed = (kk < av) ? word(ch, p0[ch] + kk) : FILLW;
      if (j >= w_addr.size()) bad++;
      else if (w_addr[j] != ea || w_data[j] !== ed || w_b1[j] !== ~b_sw || w_cyc[j] != 3 + j) bad++;
    end
    chk({tag, "_nwrites"}, w_addr.size(), NW + XS);
    chk({tag, "_bad_words"}, bad, 0);
    chk({tag, "_both_banks"}, both, 1'b0);
    chk({tag, "_first_rdreq"}, first_rd, 2);
    chk({tag, "_busy_fall"}, busy_fall, 3 + NW + XS);
    chk({tag, "_underrun"}, underrun, exp_under);
    for (int i = 0; i < CH; i++) begin
      av = (used[i] < WORDS) ? int'(used[i]) : WORDS;
      chk($sformatf("%s_rdcnt%0d", tag, i), rd_cnt[i], av);
    end
`ifdef ORB_PACKER_STATUS_EN
    if (w_addr.size() > NW) begin
      chk({tag, "_stat_addr"}, w_addr[NW], (int'(base[0]) + NW) % 2048);
      chk({tag, "_stat_data"}, w_data[NW], {exp_cnt[7:0], exp_under});
    end
`else
    if (exp_cnt < 0) chk({tag, "_cnt"}, exp_cnt, 0);
`endif
  endtask

  initial begin
    base = '{11'd0, 11'd100, 11'd200, 11'd300};
    used = '{default: 5'd20};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdreq", rdreq, 0);
    chk("rst_wren0", wren0, 0);
    chk("rst_wren1", wren1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // all FIFOs full enough, frame generator reads bank 0
    do_burst(0, 0);
    check_burst("a", 4'b0000, 1);
    chk("a_overrun", overrun, 0);
    chk("a_ch0_first", w_data[0], 12'h100);
    chk("a_ch3_last_addr", w_addr[63], 315);

    // channel 2 short, bank 1 being read
    sw      = 1'b1;
    used[2] = 5'd5;
    do_burst(0, 0);
    check_burst("b", 4'b0100, 2);
    chk("b_rd2", rd_cnt[2], 5);
    chk("b_pad_data", w_data[37], 12'hFFF);
    chk("b_pad_addr", w_addr[37], 205);
    chk("b_wren0", w_b1[0], 1'b0);

    // address wrap on channel 3, overlapping request, sw toggling mid-burst
    used[2] = 5'd20;
    base[3] = 11'd2040;
    sw      = 1'b0;
    do_burst(10, 20);
    check_burst("c", 4'b0000, 3);
    chk("c_overrun", overrun, 1);
    chk("c_wrap_2040", w_addr[48], 2040);
    chk("c_wrap_2047", w_addr[55], 2047);
    chk("c_wrap_0", w_addr[56], 0);
    chk("c_wrap_7", w_addr[63], 7);
    chk("c_bank_late", w_b1[60], 1'b1);

    // reset in the middle of a burst
    rq = 1'b0;
    @(posedge clk);
    #1;
    rq = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_rdreq", rdreq, 4'b0010);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdreq", rdreq, 0);
    chk("mid_rst_wren0", wren0, 0);
    chk("mid_rst_wren1", wren1, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_overrun", overrun, 0);
    rq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // full burst after reset, channel 1 empty
    used[1] = 5'd0;
    do_burst(0, 0);
    check_burst("d", 4'b0010, 1);
    chk("d_rd1", rd_cnt[1], 0);
    chk("d_ch1_fill", w_data[16], 12'hFFF);
    chk("d_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
